fir_output_scorer: RTL and testbench

- Receive-end scorer for the FIR_Filter output stream. It consumes the filter's `data_out` samples, discards the tap-fill warm-up samples, and compares each remaining sample against a golden sample table held inside the block.
- It produces error metrics: sum of absolute error, maximum error and its index, and mismatch count. These replace the off-line fitness parsing of `$monitor` text.
- It sits beside FIR_Filter in the bench or in an on-chip evaluation harness.

---
 rtl/fir_pkg.sv | 30 +++
 rtl/golden_ram.sv | 23 ++
 rtl/fir_output_scorer.sv | 113 +++++++++++
 tb/tb_fir_output_scorer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Shared defaults, scorer state encoding and arithmetic helpers for the FIR output scorer.
package fir_pkg;

  localparam int unsigned FIR_N    = 32;
  localparam int unsigned FIR_S    = 64;
  localparam int unsigned FIR_TAPS = 4;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    CAPTURE,
    DONE
  } state_t;

  function automatic logic [63:0] abs_diff(input logic [63:0] a, input logic [63:0] b);
    return (a > b) ? (a - b) : (b - a);
  endfunction

  // Bit 64 of the result flags saturation; the low bits hold min(a+b, 2**w-1).
  function automatic logic [64:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] wide;
    logic [64:0] lim;
    wide = {1'b0, a} + {1'b0, b};
    lim  = (65'd1 << w) - 65'd1;
    if (wide > lim) return {1'b1, lim[63:0]};
    return {1'b0, wide[63:0]};
  endfunction

endpackage

// File: rtl/golden_ram.sv
// Golden sample table: one synchronous write port, one asynchronous read port.
module golden_ram #(
  parameter int unsigned N     = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [N-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [N-1:0]  rdata
);

  logic [N-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fir_output_scorer.sv
// Scores the FIR_Filter output stream against a golden table after discarding tap-fill samples.
module fir_output_scorer
  import fir_pkg::*;
#(
  parameter int unsigned N     = FIR_N,
  parameter int unsigned S     = FIR_S,
  parameter int unsigned TAPS  = FIR_TAPS,
  parameter int unsigned AW    = 6,
  parameter int unsigned ERR_W = 40
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [N-1:0]     sample_in,
  input  logic             gold_we,
  input  logic [AW-1:0]    gold_addr,
  input  logic [N-1:0]     gold_data,
  output logic             busy,
  output logic             done,
  output logic [ERR_W-1:0] err_sum,
  output logic [N-1:0]     max_err,
  output logic [AW-1:0]    max_err_idx,
  output logic [AW:0]      mismatch_cnt,
  output logic             overflow
);

  state_t        state, state_nxt;
  logic [AW:0]   skip_cnt;
  logic [AW-1:0] idx;
  logic [N-1:0]  gold_rd;
  logic [N-1:0]  e;
  logic [64:0]   add_res;
  logic          idle_or_done;
  logic          start_run;
  logic          last_skip;
  logic          last_cmp;
  logic          gold_wr;

  assign idle_or_done = (state == IDLE) || (state == DONE);
  assign start_run    = start && idle_or_done;
  assign last_skip    = (32'(skip_cnt) == TAPS - 1);
  assign last_cmp     = (32'(idx) == S - TAPS - 1);
  assign gold_wr      = gold_we && idle_or_done && (32'(gold_addr) < S);

  golden_ram #(
    .N     (N),
    .DEPTH (S),
    .AW    (AW)
  ) u_golden_ram (
    .clk   (clk),
    .we    (gold_wr),
    .waddr (gold_addr),
    .wdata (gold_data),
    .raddr (idx),
    .rdata (gold_rd)
  );

  assign e       = N'(abs_diff(64'(sample_in), 64'(gold_rd)));
  assign add_res = sat_add(64'(err_sum), 64'(e), ERR_W);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: if (start) state_nxt = (TAPS == 0) ? CAPTURE : WARMUP;
      WARMUP:     if (sample_valid && last_skip) state_nxt = CAPTURE;
      CAPTURE:    if (sample_valid && last_cmp) state_nxt = DONE;
      default:    state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      skip_cnt     <= '0;
      idx          <= '0;
      err_sum      <= '0;
      max_err      <= '0;
      max_err_idx  <= '0;
      mismatch_cnt <= '0;
      overflow     <= 1'b0;
    end else if (start_run) begin
      skip_cnt     <= '0;
      idx          <= '0;
      err_sum      <= '0;
      max_err      <= '0;
      max_err_idx  <= '0;
      mismatch_cnt <= '0;
      overflow     <= 1'b0;
    end else if (sample_valid) begin
      if (state == WARMUP) skip_cnt <= skip_cnt + 1'b1;
      if (state == CAPTURE) begin
        err_sum <= add_res[ERR_W-1:0];
        if (add_res[64]) overflow <= 1'b1;
        // Strict compare keeps the earliest index on ties.
        if (e > max_err) begin
          max_err     <= e;
          max_err_idx <= idx;
        end
        if (e != '0) mismatch_cnt <= mismatch_cnt + 1'b1;
        idx <= idx + 1'b1;
      end
    end
  end

  assign busy = (state == WARMUP) || (state == CAPTURE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_fir_output_scorer.sv
// Directed bench for fir_output_scorer: default instance plus a narrow-accumulator instance.
module tb_fir_output_scorer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic        sample_valid;
  logic [31:0] sample_in;
  logic        gold_we;
  logic [5:0]  gold_addr;
  logic [31:0] gold_data;

  logic        busy, done, overflow;
  logic [39:0] err_sum;
  logic [31:0] max_err;
  logic [5:0]  max_err_idx;
  logic [6:0]  mismatch_cnt;

  logic        busy2, done2, overflow2;
  logic [32:0] err_sum2;
  logic [31:0] max_err2;
  logic [5:0]  max_err_idx2;
  logic [6:0]  mismatch_cnt2;

  logic [31:0] smp [64];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fir_output_scorer u_dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sample_valid(sample_valid),
    .sample_in(sample_in), .gold_we(gold_we), .gold_addr(gold_addr), .gold_data(gold_data),
    .busy(busy), .done(done), .err_sum(err_sum), .max_err(max_err),
    .max_err_idx(max_err_idx), .mismatch_cnt(mismatch_cnt), .overflow(overflow)
  );

  fir_output_scorer #(.ERR_W(33)) u_dut_sat (
    .clk(clk), .reset_n(reset_n), .start(start), .sample_valid(sample_valid),
    .sample_in(sample_in), .gold_we(gold_we), .gold_addr(gold_addr), .gold_data(gold_data),
    .busy(busy2), .done(done2), .err_sum(err_sum2), .max_err(max_err2),
    .max_err_idx(max_err_idx2), .mismatch_cnt(mismatch_cnt2), .overflow(overflow2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_gold(input logic [31:0] g);
    for (int i = 0; i < 64; i++) begin
      gold_we   = 1'b1;
      gold_addr = 6'(i);
      gold_data = g;
      tick();
    end
    gold_we = 1'b0;
  endtask

  task automatic fill(input logic [31:0] v);
    for (int i = 0; i < 64; i++) smp[i] = v;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // gap: 3 idle cycles before that sample; disturb: start + gold write with that sample;
  // abort: reset instead of that sample.
  task automatic run(input int gap, input int disturb, input int abort);
    for (int i = 0; i < 64; i++) begin
      if (i == gap) begin
        sample_valid = 1'b0;
        repeat (3) tick();
      end
      if (i == abort) begin
        sample_valid = 1'b0;
        chk("pre_reset_err_sum", 64'(err_sum), 64'd10);
        reset_n = 1'b0;
        #1;
        chk("rst_err_sum", 64'(err_sum), 64'd0);
        chk("rst_mismatch", 64'(mismatch_cnt), 64'd0);
        chk("rst_max_err", 64'(max_err), 64'd0);
        chk("rst_max_idx", 64'(max_err_idx), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        return;
      end
      sample_valid = 1'b1;
      sample_in    = smp[i];
      if (i == disturb) begin
        start     = 1'b1;
        gold_we   = 1'b1;
        gold_addr = 6'd40;
        gold_data = 32'h0;
      end
      if (i == 63) chk("done_before_last", 64'(done), 64'd0);
      tick();
      start   = 1'b0;
      gold_we = 1'b0;
      if (i == disturb) chk("busy_after_mid_start", 64'(busy), 64'd1);
    end
    sample_valid = 1'b0;
    chk("done_after_last", 64'(done), 64'd1);
  endtask

  task automatic chk_results(input string tag, input logic [63:0] esum, input logic [63:0] emm,
                             input logic [63:0] emax, input logic [63:0] eidx);
    chk({tag, "_err_sum"}, 64'(err_sum), esum);
    chk({tag, "_mismatch"}, 64'(mismatch_cnt), emm);
    chk({tag, "_max_err"}, 64'(max_err), emax);
    chk({tag, "_max_idx"}, 64'(max_err_idx), eidx);
    chk({tag, "_overflow"}, 64'(overflow), 64'd0);
  endtask

  task automatic set_two_errors();
    fill(32'h80);
    smp[10] = 32'h85;
    smp[20] = 32'h7B;
  endtask

  initial begin
    reset_n      = 1'b0;
    start        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    gold_we      = 1'b0;
    gold_addr    = '0;
    gold_data    = '0;
    repeat (3) tick();
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_err_sum", 64'(err_sum), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    reset_n = 1'b1;
    tick();

    // Clean run: constant 0x80 matches the golden table exactly.
    load_gold(32'h80);
    fill(32'h80);
    pulse_start();
    chk("busy_after_start", 64'(busy), 64'd1);
    run(-1, -1, -1);
    chk_results("clean", 64'd0, 64'd0, 64'd0, 64'd0);

    // Two errors of magnitude 5 at golden idx 6 and 16; the first wins the tie.
    set_two_errors();
    pulse_start();
    run(-1, -1, -1);
    chk_results("two_err", 64'd10, 64'd2, 64'd5, 64'd6);

    // Samples offered in DONE are ignored and results stay held.
    sample_valid = 1'b1;
    sample_in    = 32'h0;
    repeat (2) tick();
    sample_valid = 1'b0;
    chk("done_hold_err_sum", 64'(err_sum), 64'd10);
    chk("done_hold_done", 64'(done), 64'd1);

    // Warm-up samples never reach the metrics.
    fill(32'h80);
    for (int i = 0; i < 4; i++) smp[i] = 32'hFFFF_FFFF;
    pulse_start();
    run(-1, -1, -1);
    chk_results("warmup", 64'd0, 64'd0, 64'd0, 64'd0);

    // Valid gap of 3 cycles mid-capture gives the gap-free result.
    set_two_errors();
    pulse_start();
    run(15, -1, -1);
    chk_results("gap", 64'd10, 64'd2, 64'd5, 64'd6);

    // Mid-capture start and golden write (idx 40 -> 0) are both ignored.
    pulse_start();
    run(-1, 30, -1);
    chk_results("disturb", 64'd10, 64'd2, 64'd5, 64'd6);

    // Reset mid-capture, then a full run on the retained table.
    pulse_start();
    run(-1, -1, 30);
    pulse_start();
    run(-1, -1, -1);
    chk_results("after_reset", 64'd10, 64'd2, 64'd5, 64'd6);

    // Saturation on the 33-bit instance; 40 bits holds 60 * 0xFFFFFFFF exactly.
    load_gold(32'h0);
    fill(32'hFFFF_FFFF);
    pulse_start();
    run(-1, -1, -1);
    chk("sat_err_sum", 64'(err_sum2), 64'h1_FFFF_FFFF);
    chk("sat_overflow", 64'(overflow2), 64'd1);
    chk("sat_done", 64'(done2), 64'd1);
    chk("wide_err_sum", 64'(err_sum), 64'd257698037700);
    chk("wide_overflow", 64'(overflow), 64'd0);
    chk("wide_mismatch", 64'(mismatch_cnt), 64'd60);
    chk("wide_max_err", 64'(max_err), 64'hFFFF_FFFF);
    chk("wide_max_idx", 64'(max_err_idx), 64'd0);
    repeat (3) tick();
    chk("sat_overflow_sticky", 64'(overflow2), 64'd1);
    chk("sat_err_sum_held", 64'(err_sum2), 64'h1_FFFF_FFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
